// File: rtl/seg_pkg.sv
// Shared types and widths for the segment display arbiter.
// State encodings and bus widths used by the RTL and the bench.
package seg_pkg;

    localparam int DATA_W  = 20;
    localparam int POINT_W = 6;
    localparam int CNT_W   = 23;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Two display sources plus the arbitrated display-driver bundle.
// The master side drives source requests; the slave side is the arbiter.
interface seg_disp_arbiter_if;
    import seg_pkg::*;

    logic               req0;
    logic [DATA_W-1:0]  data0;
    logic [POINT_W-1:0] point0;
    logic               sign0;
    logic               seg_en0;

    logic               req1;
    logic [DATA_W-1:0]  data1;
    logic [POINT_W-1:0] point1;
    logic               sign1;
    logic               seg_en1;

    logic               gnt0;
    logic               gnt1;
    logic [DATA_W-1:0]  data;
    logic [POINT_W-1:0] point;
    logic               sign;
    logic               seg_en;

    modport master (
        output req0, data0, point0, sign0, seg_en0,
        output req1, data1, point1, sign1, seg_en1,
        input  gnt0, gnt1, data, point, sign, seg_en
    );

    modport slave (
        input  req0, data0, point0, sign0, seg_en0,
        input  req1, data1, point1, sign1, seg_en1,
        output gnt0, gnt1, data, point, sign, seg_en
    );

endinterface

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing the six-digit display between two sources.
// A grant is held at least CNT_HOLD_MAX+1 cycles before the other side may preempt.
module seg_disp_arbiter
    import seg_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_HOLD_MAX = 23'd4_999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    seg_disp_arbiter_if.slave bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               last_gnt_q, last_gnt_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [POINT_W-1:0] point_q, point_d;
    logic               sign_q, sign_d;
    logic               seg_en_q, seg_en_d;
    logic               hold_done;

    assign hold_done = (hold_cnt_q == CNT_HOLD_MAX);

    // Next grant: release, hold-expiry preemption, or fresh arbitration.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_gnt_q ? GNT0 : GNT1;
                end else if (bus.req0) begin
                    state_d = GNT0;
                end else if (bus.req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? GNT1 : IDLE;
                end else if (hold_done && bus.req1) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? GNT0 : IDLE;
                end else if (hold_done && bus.req0) begin
                    state_d = GNT0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold counter restarts on every new grant and saturates while held.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        last_gnt_d = last_gnt_q;
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == GNT0) last_gnt_d = 1'b0;
            if (state_d == GNT1) last_gnt_d = 1'b1;
        end else if (state_q == IDLE) begin
            hold_cnt_d = '0;
        end else if (!hold_done) begin
            hold_cnt_d = hold_cnt_q + 23'd1;
        end
    end

    // Grant flags decode the next state; display regs follow the current owner.
    always_comb begin
        gnt0_d   = (state_d == GNT0);
        gnt1_d   = (state_d == GNT1);
        data_d   = '0;
        point_d  = '0;
        sign_d   = 1'b0;
        seg_en_d = 1'b0;
        if (state_q == GNT0) begin
            data_d   = bus.data0;
            point_d  = bus.point0;
            sign_d   = bus.sign0;
            seg_en_d = bus.seg_en0;
        end else if (state_q == GNT1) begin
            data_d   = bus.data1;
            point_d  = bus.point1;
            sign_d   = bus.sign1;
            seg_en_d = bus.seg_en1;
        end
    end

    // State, counter and output registers, cleared asynchronously.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            data_q     <= '0;
            point_q    <= '0;
            sign_q     <= 1'b0;
            seg_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            data_q     <= data_d;
            point_q    <= point_d;
            sign_q     <= sign_d;
            seg_en_q   <= seg_en_d;
        end
    end

    assign bus.gnt0   = gnt0_q;
    assign bus.gnt1   = gnt1_q;
    assign bus.data   = data_q;
    assign bus.point  = point_q;
    assign bus.sign   = sign_q;
    assign bus.seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with a short hold time.
// Table vectors first, then round-robin, release, saturation and reset sequences.
module tb_seg_disp_arbiter;
    import seg_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    seg_disp_arbiter_if ifc ();

    seg_disp_arbiter #(
        .CNT_HOLD_MAX(23'd9)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (ifc.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        req0;
        logic [19:0] d0;
        logic [5:0]  p0;
        logic        s0;
        logic        e0;
        logic        req1;
        logic [19:0] d1;
        logic [5:0]  p1;
        logic        s1;
        logic        e1;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [29:0] mk(input logic g0, input logic g1,
                                       input logic [19:0] d, input logic [5:0] p,
                                       input logic s, input logic e);
        return {g0, g1, d, p, s, e};
    endfunction

    function automatic logic [29:0] outs();
        return {ifc.gnt0, ifc.gnt1, ifc.data, ifc.point, ifc.sign, ifc.seg_en};
    endfunction

    task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input vec_t v);
        ifc.req0    = v.req0;
        ifc.data0   = v.d0;
        ifc.point0  = v.p0;
        ifc.sign0   = v.s0;
        ifc.seg_en0 = v.e0;
        ifc.req1    = v.req1;
        ifc.data1   = v.d1;
        ifc.point1  = v.p1;
        ifc.sign1   = v.s1;
        ifc.seg_en1 = v.e1;
    endtask

    initial begin
        vec_t z;
        logic [29:0] e;
        n_cmp = 0;
        n_bad = 0;

        z = '{1'b0, 20'd0, 6'd0, 1'b0, 1'b0, 1'b0, 20'd0, 6'd0, 1'b0, 1'b0, 30'd0};
        tbl[0]  = z;
        tbl[1]  = '{1'b1, 20'd123456, 6'b000100, 1'b0, 1'b1, 1'b0, 20'd0, 6'd0, 1'b0, 1'b0,
                    mk(1, 0, 20'd0, 6'd0, 0, 0)};
        tbl[2]  = '{1'b1, 20'd123456, 6'b000100, 1'b0, 1'b1, 1'b0, 20'd0, 6'd0, 1'b0, 1'b0,
                    mk(1, 0, 20'd123456, 6'b000100, 0, 1)};
        tbl[3]  = '{1'b1, 20'd654321, 6'b000100, 1'b1, 1'b1, 1'b0, 20'd0, 6'd0, 1'b0, 1'b0,
                    mk(1, 0, 20'd654321, 6'b000100, 1, 1)};
        tbl[4]  = '{1'b1, 20'd654321, 6'b000100, 1'b1, 1'b1, 1'b0, 20'd999999, 6'h3f, 1'b1, 1'b1,
                    mk(1, 0, 20'd654321, 6'b000100, 1, 1)};
        tbl[5]  = '{1'b0, 20'd654321, 6'b000100, 1'b1, 1'b1, 1'b0, 20'd999999, 6'h3f, 1'b1, 1'b1,
                    mk(0, 0, 20'd654321, 6'b000100, 1, 1)};
        tbl[6]  = z;
        tbl[7]  = '{1'b0, 20'd5, 6'd1, 1'b1, 1'b1, 1'b1, 20'd111111, 6'b100000, 1'b0, 1'b1,
                    mk(0, 1, 20'd0, 6'd0, 0, 0)};
        tbl[8]  = '{1'b0, 20'd5, 6'd1, 1'b1, 1'b1, 1'b1, 20'd111111, 6'b100000, 1'b0, 1'b1,
                    mk(0, 1, 20'd111111, 6'b100000, 0, 1)};
        tbl[9]  = '{1'b0, 20'd5, 6'd1, 1'b1, 1'b1, 1'b0, 20'd111111, 6'b100000, 1'b0, 1'b1,
                    mk(0, 0, 20'd111111, 6'b100000, 0, 1)};
        tbl[10] = z;

        set_src(z);
        rst_n = 1'b0;
        step();
        step();
        chk("reset_hold", outs(), 30'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            set_src(tbl[i]);
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // both request from IDLE: src0 first, then round-robin every 10 cycles
        ifc.req0 = 1'b1; ifc.data0 = 20'd1; ifc.point0 = 6'd1; ifc.sign0 = 1'b0; ifc.seg_en0 = 1'b1;
        ifc.req1 = 1'b1; ifc.data1 = 20'd2; ifc.point1 = 6'd2; ifc.sign1 = 1'b0; ifc.seg_en1 = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            step();
            if (k == 0)
                e = mk(1, 0, 20'd0, 6'd0, 0, 0);
            else if (k <= 9)
                e = mk(1, 0, 20'd1, 6'd1, 0, 1);
            else if (k == 10)
                e = mk(0, 1, 20'd1, 6'd1, 0, 1);
            else if (k <= 19)
                e = mk(0, 1, 20'd2, 6'd2, 0, 1);
            else
                e = mk(1, 0, 20'd2, 6'd2, 0, 1);
            chk($sformatf("rr_k%0d", k), outs(), e);
        end

        // src0 releases: straight to GNT1, then GNT1 released at hold 3 with no other req
        ifc.req0 = 1'b0;
        step();
        chk("rel0_to_gnt1", outs(), mk(0, 1, 20'd1, 6'd1, 0, 1));
        step();
        step();
        step();
        chk("gnt1_hold3", outs(), mk(0, 1, 20'd2, 6'd2, 0, 1));
        ifc.req1 = 1'b0;
        step();
        chk("rel1_idle", outs(), mk(0, 0, 20'd2, 6'd2, 0, 1));
        step();
        chk("idle_zero", outs(), 30'd0);

        // GNT1 released at hold 3 while src0 waits: direct handover
        ifc.req1 = 1'b1;
        step();
        step();
        step();
        step();
        chk("gnt1_again", outs(), mk(0, 1, 20'd2, 6'd2, 0, 1));
        ifc.req1 = 1'b0;
        ifc.req0 = 1'b1;
        step();
        chk("rel1_to_gnt0", outs(), mk(1, 0, 20'd2, 6'd2, 0, 1));

        // single requester keeps the grant; counter must sit at its maximum
        for (int k = 0; k < 50; k++) begin
            step();
            chk($sformatf("solo_k%0d", k), {28'd0, ifc.gnt0, ifc.gnt1}, 30'd2);
        end
        ifc.req1 = 1'b1;
        step();
        chk("sat_preempt", {28'd0, ifc.gnt0, ifc.gnt1}, 30'd1);
        step();
        step();
        chk("gnt1_live", outs(), mk(0, 1, 20'd2, 6'd2, 0, 1));

        // asynchronous reset in the middle of a cycle
        #7;
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), 30'd0);
        step();
        chk("rst_edge", outs(), 30'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_tie", outs(), mk(1, 0, 20'd0, 6'd0, 0, 0));
        step();
        chk("post_rst_data", outs(), mk(1, 0, 20'd1, 6'd1, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
